// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the multicycle execution stage:
// operation codes, FSM state encoding and default widths.
package alu_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;
  localparam int OP_WIDTH        = 4;

  // Operation codes produced by the ALU control decoder
  localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_WIDTH-1:0] ALU_AND = 4'b0010;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'b0011;
  localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'b0100;
  localparam logic [OP_WIDTH-1:0] ALU_LUI = 4'b0101;
  localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'b0110;
  localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // True for the op codes that take the iterative shift path
  function automatic logic is_shift(input logic [OP_WIDTH-1:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU evaluator: ADD/SUB/AND/OR/XOR/LUI. Any other code yields 0;
// shift codes are handled by the iterative path in the top level.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Select the single-cycle result; add/sub wrap modulo 2^DATA_WIDTH
  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_LUI: o_result = i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execution stage behind the ALU control decoder. Single-cycle ops finish on the
// accepting edge; SRL/SLL iterate one bit per cycle behind a start/busy/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  alu_state_t              r_state;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [SHAMT_WIDTH-1:0]  r_count;
  logic                    r_srl;
  logic                    r_busy;
  logic                    r_done;

  logic [DATA_WIDTH-1:0]   w_core_result;
  logic [DATA_WIDTH-1:0]   w_single_result;
  logic [DATA_WIDTH-1:0]   w_acc_next;
  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic                    w_is_shift;

  alu_comb_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .i_op     (ALU_Operation_i),
    .i_a      (A_i),
    .i_b      (B_i),
    .o_result (w_core_result)
  );

  assign w_shamt    = B_i[SHAMT_WIDTH-1:0];
  assign w_is_shift = is_shift(ALU_Operation_i);

  // A shift by zero completes immediately and simply passes A through
  assign w_single_result = w_is_shift ? A_i : w_core_result;

  // One bit of shift per cycle, zero fill in both directions
  assign w_acc_next = r_srl ? (r_acc >> 1) : (r_acc << 1);

  // Control FSM with registered busy/done and the result register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the shift accumulator and counter are reset along with control so an
    // aborted shift leaves no stale datapath state behind.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_srl    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register see the pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_acc   <= A_i;
              r_count <= w_shamt;
              r_srl   <= (ALU_Operation_i == ALU_SRL);
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end else begin
              r_result <= w_single_result;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_acc   <= w_acc_next;
          r_count <= r_count - SHAMT_WIDTH'(1);
          if (r_count == SHAMT_WIDTH'(1)) begin
            r_result <= w_acc_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign ALU_Result_o = r_result;
  assign Zero_o       = (r_result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle. The driver pushes each expected result into a
// scoreboard queue; a monitor pops and compares whenever done_o is seen.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;

  typedef struct {
    logic [31:0] res;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] prev_result = '0;

  alu_multicycle #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares on every done_o pulse, and otherwise checks that the result holds
  always @(negedge clk) begin
    if (reset) begin
      prev_result = '0;
    end else if (done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected done_o", ALU_Result_o, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.nm, " result"}, ALU_Result_o, e.res);
        check({e.nm, " zero"}, {31'b0, Zero_o}, {31'b0, (e.res == 32'h0)});
      end
      prev_result = ALU_Result_o;
    end else begin
      check("result hold", ALU_Result_o, prev_result);
    end
  end

  // Issue one op; measure accept-to-done latency and busy cycles. pulse_at>0 raises
  // start_i (with different operands) for one cycle at that point of the wait.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int pulse_at);
    int   lat;
    int   busy_cnt;
    exp_t e;
    ALU_Operation_i = op;
    A_i             = a;
    B_i             = b;
    start_i         = 1'b1;
    e.res = exp_res;
    e.nm  = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done_o && lat < 64) begin
      if (busy_o) busy_cnt++;
      if (lat == pulse_at) begin
        start_i         = 1'b1;
        ALU_Operation_i = ALU_ADD;
        A_i             = 32'hDEAD_BEEF;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start_i = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    start_i         = 1'b0;
    ALU_Operation_i = ALU_ADD;
    A_i             = '0;
    B_i             = '0;
    #12;
    check("reset result", ALU_Result_o, 32'h0);
    check("reset zero",   {31'b0, Zero_o}, 32'h1);
    check("reset busy",   {31'b0, busy_o}, 32'h0);
    check("reset done",   {31'b0, done_o}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: ADD overflow wraps
    run_op("add ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
    // 2: SUB to zero, then SUB issued in the DONE cycle
    run_op("sub zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1, 0);
    run_op("sub b2b",  ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    // 3: longest SRL with an ignored mid-shift start pulse
    run_op("srl 31", ALU_SRL, 32'h8000_0000, 32'h1F, 32'h0000_0001, 32, 5);
    // 4: shift amount zero, and upper B bits ignored
    run_op("sll sh0", ALU_SLL, 32'hA5, 32'h20, 32'hA5, 1, 0);
    run_op("sll sh5", ALU_SLL, 32'h1, 32'h25, 32'h20, 6, 0);
    run_op("srl b2b", ALU_SRL, 32'hF000_0000, 32'h4, 32'h0F00_0000, 5, 0);
    // 6: LUI, undefined op, logic ops
    run_op("lui",   ALU_LUI, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000, 1, 0);
    run_op("undef", 4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1, 0);
    run_op("and",   ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1, 0);
    run_op("or",    ALU_OR,  32'hF0F0, 32'hFF00, 32'hFFF0, 1, 0);
    run_op("xor",   ALU_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1, 0);
    repeat (2) @(posedge clk);
    #1;

    // 5: asynchronous reset aborts an SLL in flight; no done_o may follow
    ALU_Operation_i = ALU_SLL;
    A_i             = 32'h1;
    B_i             = 32'd31;
    start_i         = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("sll busy before abort", {31'b0, busy_o}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy",   {31'b0, busy_o}, 32'h0);
    check("abort done",   {31'b0, done_o}, 32'h0);
    check("abort result", ALU_Result_o, 32'h0);
    check("abort zero",   {31'b0, Zero_o}, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    run_op("add after rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
